case_4_mac_pipe: RTL and testbench
==================================

Name: case_4_mac_pipe

Overview:
- Parametrised, pipelined integer multiplier / multiply-accumulate operator for the HLS datapath library.
- Successor to the combinational fixed-signed multiplier cores. Adds:
  - configurable pipeline depth;
  - per-operand signedness;
  - clock-enable stalling;
  - valid tracking;
  - an optional accumulate mode with sticky overflow.
- Instantiated by generated kernels wherever a multiply sits on a pipelined loop body or a reduction.

Parameters:
- ID, 1, instance tag; no functional effect.
- NUM_STAGE, 2, product pipeline registers, legal 1..4.
- din0_WIDTH, 9, operand A width.
- din1_WIDTH, 7, operand B width.
- dout_WIDTH, 13, result/accumulator width.
- din0_SIGNED, 1, 1 = din0 two's complement, 0 = unsigned.
- din1_SIGNED, 1, 1 = din1 two's complement, 0 = unsigned.
- ACC_EN, 0, 0 = multiply mode, 1 = multiply-accumulate mode.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- ce  in  1  clock enable; 0 freezes every register except reset.
- din_vld  in  1  operands valid this cycle.
- din0  in  din0_WIDTH  operand A.
- din1  in  din1_WIDTH  operand B.
- acc_clr  in  1  sampled with din_vld; the sample starts a new sum (ACC_EN=1 only).
- dout  out  dout_WIDTH  product (ACC_EN=0) or accumulator (ACC_EN=1).
- dout_vld  out  1  dout holds a new result.
- ovf  out  1  sticky accumulator overflow (constant 0 when ACC_EN=0).

Behaviour:
- Reset:
  - Reset is synchronous and dominates ce.
  - Clears all pipeline data and valid bits, the accumulator and ovf.
  - After reset: dout=0, dout_vld=0, ovf=0.
  - Reset mid-operation discards every in-flight sample; no dout_vld follows it.
- Arithmetic:
  - Each operand is extended by one bit: sign-extended if its SIGNED=1, zero-extended otherwise.
  - Full product is computed signed at din0_WIDTH+din1_WIDTH+2 bits.
  - Result is signed if either operand is signed.
  - Mapping to dout_WIDTH:
    - narrower: keep the low bits (wrap, no saturation);
    - wider: sign-extend if the result is signed, zero-extend otherwise.
- Pipeline:
  - Stage 1 registers din0, din1, din_vld and acc_clr when ce=1.
  - The multiply may be retimed anywhere across stages 1..NUM_STAGE.
  - When ce=0 all stages, valid bits, accumulator and outputs hold.
- ACC_EN=0:
  - dout and dout_vld are the last-stage registers.
  - Latency: NUM_STAGE ce-enabled cycles from sampling to dout_vld=1.
  - dout holds its last value while dout_vld=0.
- ACC_EN=1:
  - Accumulator update happens when the last-stage valid is 1 and ce=1:
    - acc <= (clr_pipe ? 0 : acc) + product, modulo 2^dout_WIDTH.
  - dout = acc. dout_vld pulses one cycle after each update.
  - Latency: NUM_STAGE+1 ce-enabled cycles.
- acc_clr:
  - acc_clr with din_vld=0 is ignored.
  - acc_clr travels with its sample, so back-to-back clears each start a fresh sum.
- ovf:
  - Signed result: set when addends share a sign and the sum's sign differs.
  - Unsigned result: set on carry out.
  - ovf is computed against the pre-add value, i.e. 0 when clr_pipe=1.
  - Sticky until reset or a clr sample updates the accumulator. That update sets ovf from the new add only.
- Throughput: one sample per ce-enabled cycle, no bubbles. Consecutive valid samples produce consecutive dout_vld pulses.
- din_vld=0 samples propagate as bubbles: no dout_vld, accumulator unchanged.

Test Plan:
1. Signed multiply, defaults (NUM_STAGE=2, ACC_EN=0): din0=100, din1=-3, din_vld=1 for one cycle -> two cycles later dout=0x1ED4 (-300), dout_vld=1 for exactly one cycle.
2. Wrap at the corner value: din0=-256, din1=-64 -> dout=0 (16384 mod 8192). Unsigned mode with din0_SIGNED=0, din1_SIGNED=0: din0=511, din1=127 -> dout=7553.
3. Streaming with stall: inputs (2,3),(4,5),(6,7) on consecutive cycles, ce=0 for 2 cycles mid-stream -> outputs 6, 20, 42 in order, dout_vld delayed by exactly 2 cycles, no loss or duplication.
4. Accumulate (ACC_EN=1, signed): (10,10,clr=1), (5,-4), (3,3) -> dout 100, 80, 89 on successive dout_vld, ovf=0. Then (100,40,clr=1), (100,30) -> dout 4000, then -1192 with ovf=1. ovf stays 1 until a new clr sample.
5. Reset mid-operation: two valid samples in flight, reset=1 for one cycle -> dout=0, dout_vld=0, ovf=0, and no dout_vld from the discarded samples. The next sample yields a normal result at full latency.
6. Sweep NUM_STAGE=1..4 with random signed/unsigned operands against a reference model -> latency equals NUM_STAGE (ACC_EN=0) or NUM_STAGE+1 (ACC_EN=1), and every value matches.

Source files
------------

// File: rtl/case_4_mac_pipe.sv
// case_4_mac_pipe: pipelined integer multiplier / multiply-accumulate.
//   Each operand is widened by one bit (sign- or zero-extended by its *_SIGNED
//   parameter), the product is formed signed at din0_WIDTH+din1_WIDTH+2 bits
//   and mapped to dout_WIDTH (wrap when narrower, extend when wider).
//   ACC_EN=0: dout/dout_vld are the last product stage, latency NUM_STAGE.
//   ACC_EN=1: last stage feeds an accumulator with sticky overflow,
//             latency NUM_STAGE+1.
// Ports:
//   clk, reset (sync, active high, dominates ce), ce (global stall)
//   din_vld, din0, din1, acc_clr  : input sample
//   dout, dout_vld, ovf           : result / accumulator, valid, sticky overflow
module case_4_mac_pipe #(
  parameter int ID          = 1,
  parameter int NUM_STAGE   = 2,
  parameter int din0_WIDTH  = 9,
  parameter int din1_WIDTH  = 7,
  parameter int dout_WIDTH  = 13,
  parameter int din0_SIGNED = 1,
  parameter int din1_SIGNED = 1,
  parameter int ACC_EN      = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  din_vld,
  input  logic [din0_WIDTH-1:0] din0,
  input  logic [din1_WIDTH-1:0] din1,
  input  logic                  acc_clr,
  output logic [dout_WIDTH-1:0] dout,
  output logic                  dout_vld,
  output logic                  ovf
);
  localparam int  NS = NUM_STAGE;
  localparam int  DW = dout_WIDTH;
  localparam int  PW = din0_WIDTH + din1_WIDTH + 2;
  localparam bit  RS = (din0_SIGNED != 0) || (din1_SIGNED != 0);
  // instance tag only
  localparam int  unused_id = ID;

  // ---------------- operand extension and product ----------------
  logic signed [din0_WIDTH:0] w_a;
  logic signed [din1_WIDTH:0] w_b;
  logic signed [PW-1:0]       w_ax, w_bx, w_prod;
  logic        [DW-1:0]       w_res;

  assign w_a    = {(din0_SIGNED != 0) ? din0[din0_WIDTH-1] : 1'b0, din0};
  assign w_b    = {(din1_SIGNED != 0) ? din1[din1_WIDTH-1] : 1'b0, din1};
  assign w_ax   = {{(PW-din0_WIDTH-1){w_a[din0_WIDTH]}}, w_a};
  assign w_bx   = {{(PW-din1_WIDTH-1){w_b[din1_WIDTH]}}, w_b};
  assign w_prod = w_ax * w_bx;

  if (DW < PW) begin : g_narrow
    // wrap: high product bits are deliberately dropped
    logic w_unused_hi;
    assign w_unused_hi = ^w_prod[PW-1:DW];
    assign w_res       = w_prod[DW-1:0];
  end else if (DW == PW) begin : g_equal
    assign w_res = w_prod;
  end else begin : g_wide
    assign w_res = {{(DW-PW){RS & w_prod[PW-1]}}, w_prod};
  end

  // ---------------- product pipeline ----------------
  // The multiply is folded into stage 1; later stages only delay. Data
  // registers load only behind a valid sample so bubbles leave them intact.
  logic [NS:1]         r_vld_pipe;
  logic [NS:1]         r_clr_pipe;
  logic [NS:1][DW-1:0] r_p_pipe;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vld_pipe <= '0;
      r_clr_pipe <= '0;
      r_p_pipe   <= '0;
    end else if (ce) begin
      r_vld_pipe[1] <= din_vld;
      r_clr_pipe[1] <= din_vld & acc_clr;
      if (din_vld) r_p_pipe[1] <= w_res;
      for (int s = 2; s <= NS; s++) begin
        r_vld_pipe[s] <= r_vld_pipe[s-1];
        r_clr_pipe[s] <= r_clr_pipe[s-1];
        if (r_vld_pipe[s-1]) r_p_pipe[s] <= r_p_pipe[s-1];
      end
    end
  end

  // ---------------- output section ----------------
  if (ACC_EN != 0) begin : g_acc
    logic [DW-1:0] r_acc;
    logic          r_dv;
    logic          r_ovf;
    logic [DW-1:0] w_base;
    logic [DW:0]   w_sum;
    logic          w_add_ovf;

    // a clear sample restarts the sum from zero, so overflow is judged
    // against zero rather than the old accumulator
    assign w_base = r_clr_pipe[NS] ? '0 : r_acc;
    assign w_sum  = {1'b0, w_base} + {1'b0, r_p_pipe[NS]};

    always_comb begin
      w_add_ovf = 1'b0;
      if (RS)
        w_add_ovf = (w_base[DW-1] == r_p_pipe[NS][DW-1]) &&
                    (w_sum[DW-1] != w_base[DW-1]);
      else
        w_add_ovf = w_sum[DW];
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        r_acc <= '0;
        r_dv  <= 1'b0;
        r_ovf <= 1'b0;
      end else if (ce) begin
        r_dv <= r_vld_pipe[NS];
        if (r_vld_pipe[NS]) begin
          r_acc <= w_sum[DW-1:0];
          r_ovf <= r_clr_pipe[NS] ? w_add_ovf : (r_ovf | w_add_ovf);
        end
      end
    end

    assign dout     = r_acc;
    assign dout_vld = r_dv;
    assign ovf      = r_ovf;
  end else begin : g_mul
    logic w_unused_clr;
    assign w_unused_clr = ^r_clr_pipe;
    assign dout         = r_p_pipe[NS];
    assign dout_vld     = r_vld_pipe[NS];
    assign ovf          = 1'b0;
  end

endmodule

// File: tb/tb_case_4_mac_pipe.sv
// Bench for case_4_mac_pipe: several instances (multiply / accumulate, mixed
// signedness, NUM_STAGE 1..4) share one stimulus stream; a queue-based model
// of "result due after N enabled cycles" predicts every output every cycle.
module tb_case_4_mac_pipe;
  localparam int NI = 11;
  localparam int DW = 13;
  localparam longint MASK = 8191;

  function automatic int ns_of(int i);
    if (i < 3) return 2;
    else if (i < 7) return i - 2;
    else return i - 6;
  endfunction
  function automatic int s0_of(int i);
    return (i == 1 || i >= 7) ? 0 : 1;
  endfunction
  function automatic int s1_of(int i);
    return (i == 1 || (i >= 3 && i < 7)) ? 0 : 1;
  endfunction
  function automatic int acc_of(int i);
    return (i == 2 || i >= 7) ? 1 : 0;
  endfunction

  logic clk, reset, ce, din_vld, acc_clr;
  logic [8:0] din0;
  logic [6:0] din1;
  logic [NI-1:0][DW-1:0] w_dout;
  logic [NI-1:0]         w_dv;
  logic [NI-1:0]         w_ovf;

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    case_4_mac_pipe #(
      .ID(gi), .NUM_STAGE(ns_of(gi)), .din0_WIDTH(9), .din1_WIDTH(7),
      .dout_WIDTH(DW), .din0_SIGNED(s0_of(gi)), .din1_SIGNED(s1_of(gi)),
      .ACC_EN(acc_of(gi))
    ) u_dut (
      .clk(clk), .reset(reset), .ce(ce), .din_vld(din_vld),
      .din0(din0), .din1(din1), .acc_clr(acc_clr),
      .dout(w_dout[gi]), .dout_vld(w_dv[gi]), .ovf(w_ovf[gi])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_tot++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    longint     due;
    logic [12:0] val;
    logic       clr;
  } item_t;

  item_t  q [NI][$];
  longint e_dout [NI];
  bit     e_vld  [NI];
  bit     e_ovf  [NI];
  longint kce;
  bit     last_ce;
  longint seen0[$];
  longint seen2[$];
  longint seen2o[$];

  function automatic longint sx(longint x, int w);
    if (((x >> (w - 1)) & 1) != 0) return x - (longint'(1) << w);
    return x;
  endfunction

  function automatic longint prod_of(int i, longint a_raw, longint b_raw);
    longint a, b;
    a = (s0_of(i) != 0) ? sx(a_raw, 9) : a_raw;
    b = (s1_of(i) != 0) ? sx(b_raw, 7) : b_raw;
    return (a * b) & MASK;
  endfunction

  task automatic model_edge();
    item_t  it;
    longint base, sum, t;
    bit     o;
    if (reset) begin
      kce = 0;
      for (int i = 0; i < NI; i++) begin
        q[i].delete();
        e_dout[i] = 0; e_vld[i] = 0; e_ovf[i] = 0;
      end
    end else if (ce) begin
      kce++;
      for (int i = 0; i < NI; i++) begin
        if (din_vld) begin
          it.due = kce + ns_of(i) + acc_of(i) - 1;
          it.val = 13'(prod_of(i, longint'(din0), longint'(din1)));
          it.clr = acc_clr;
          q[i].push_back(it);
        end
        if (q[i].size() > 0 && q[i][0].due == kce) begin
          it = q[i].pop_front();
          e_vld[i] = 1;
          if (acc_of(i) != 0) begin
            base = it.clr ? 0 : e_dout[i];
            sum  = base + longint'(it.val);
            if (s0_of(i) != 0 || s1_of(i) != 0) begin
              t = sx(base, DW) + sx(longint'(it.val), DW);
              o = (t > 4095) || (t < -4096);
            end else begin
              o = sum > MASK;
            end
            e_dout[i] = sum & MASK;
            e_ovf[i]  = it.clr ? o : (e_ovf[i] | o);
          end else begin
            e_dout[i] = longint'(it.val);
          end
        end else begin
          e_vld[i] = 0;
        end
      end
    end
  endtask

  // one clock: model at the edge, compare all instances half a cycle later
  task automatic cyc();
    @(posedge clk);
    model_edge();
    last_ce = ce && !reset;
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk($sformatf("dout%0d", i), longint'(w_dout[i]), e_dout[i]);
      chk($sformatf("vld%0d", i), longint'(w_dv[i]), longint'(e_vld[i]));
      chk($sformatf("ovf%0d", i), longint'(w_ovf[i]), longint'(e_ovf[i]));
    end
    if (w_dv[0] && last_ce) seen0.push_back(longint'(w_dout[0]));
    if (w_dv[2] && last_ce) begin
      seen2.push_back(longint'(w_dout[2]));
      seen2o.push_back(longint'(w_ovf[2]));
    end
  endtask

  task automatic drv(input bit v, input int a, input int b, input bit c);
    din_vld = v;
    din0    = 9'(a);
    din1    = 7'(b);
    acc_clr = c;
  endtask

  task automatic chk_seen(input string tag, input longint got_q[$],
                          input longint exp_q[$]);
    chk({tag, "_n"}, longint'(got_q.size()), longint'(exp_q.size()));
    for (int j = 0; j < exp_q.size(); j++)
      if (j < got_q.size()) chk($sformatf("%s_%0d", tag, j), got_q[j], exp_q[j]);
  endtask

  initial begin
    int ghost;
    kce = 0; last_ce = 0;
    ce = 1; reset = 1;
    drv(0, 0, 0, 0);
    cyc(); cyc();
    for (int i = 0; i < NI; i++) begin
      chk("rst_dout", longint'(w_dout[i]), 0);
      chk("rst_vld",  longint'(w_dv[i]), 0);
      chk("rst_ovf",  longint'(w_ovf[i]), 0);
    end
    reset = 0;

    // signed multiply, two-cycle latency, single pulse, hold
    drv(1, 100, -3, 0); cyc();
    drv(0, 0, 0, 0);    cyc();
    chk("t1_dout", longint'(w_dout[0]), 'h1ED4);
    chk("t1_vld", longint'(w_dv[0]), 1);
    cyc();
    chk("t1_pulse", longint'(w_dv[0]), 0);
    chk("t1_hold", longint'(w_dout[0]), 'h1ED4);

    // corner wrap (signed) and full-scale unsigned
    drv(1, -256, -64, 0); cyc();
    drv(1, 511, 127, 0);  cyc();
    chk("t2_wrap", longint'(w_dout[0]), 0);
    drv(0, 0, 0, 0);      cyc();
    chk("t2_uns", longint'(w_dout[1]), 7553);
    repeat (3) cyc();

    // streaming with a two-cycle stall
    seen0.delete();
    drv(1, 2, 3, 0); cyc();
    drv(1, 4, 5, 0); cyc();
    ce = 0; drv(1, 6, 7, 0); cyc(); cyc();
    ce = 1; cyc();
    drv(0, 0, 0, 0); repeat (4) cyc();
    chk_seen("t3", seen0, '{6, 20, 42});

    // accumulate
    seen2.delete(); seen2o.delete();
    drv(1, 10, 10, 1); cyc();
    drv(1, 5, -4, 0);  cyc();
    drv(1, 3, 3, 0);   cyc();
    drv(0, 0, 0, 0);   repeat (4) cyc();
    chk_seen("t4a", seen2, '{100, 80, 89});
    chk_seen("t4a_ovf", seen2o, '{0, 0, 0});
    seen2.delete(); seen2o.delete();
    drv(1, 100, 40, 1); cyc();
    drv(1, 100, 30, 0); cyc();
    drv(0, 0, 0, 0);    repeat (4) cyc();
    chk_seen("t4b", seen2, '{4000, 8192 - 1192});
    chk_seen("t4b_ovf", seen2o, '{0, 1});
    drv(1, 1, 1, 0); cyc();
    drv(0, 0, 0, 0); repeat (4) cyc();
    chk("t4_sticky", longint'(w_ovf[2]), 1);
    drv(1, 1, 1, 1); cyc();
    drv(0, 0, 0, 0); repeat (4) cyc();
    chk("t4_clr_ovf", longint'(w_ovf[2]), 0);
    chk("t4_clr_dout", longint'(w_dout[2]), 1);

    // reset with samples in flight
    drv(1, 7, 9, 0); cyc();
    drv(1, 3, 3, 0); cyc();
    reset = 1; drv(0, 0, 0, 0); cyc();
    chk("t5_dout0", longint'(w_dout[0]), 0);
    chk("t5_vld0", longint'(w_dv[0]), 0);
    chk("t5_dout2", longint'(w_dout[2]), 0);
    chk("t5_ovf2", longint'(w_ovf[2]), 0);
    reset = 0;
    ghost = 0;
    repeat (6) begin
      cyc();
      ghost += int'(w_dv[0]) + int'(w_dv[2]) + int'(w_dv[6]);
    end
    chk("t5_ghost", longint'(ghost), 0);
    drv(1, 5, 6, 0); cyc();
    drv(0, 0, 0, 0); cyc();
    chk("t5_lat_vld", longint'(w_dv[0]), 1);
    chk("t5_lat_dout", longint'(w_dout[0]), 30);
    repeat (4) cyc();

    // randomized sweep across all instances
    repeat (1500) begin
      reset   = ($urandom_range(0, 99) == 0);
      ce      = ($urandom_range(0, 4) != 0);
      din_vld = ($urandom_range(0, 9) < 7);
      acc_clr = ($urandom_range(0, 4) == 0);
      case ($urandom_range(0, 3))
        0:       din0 = 9'h100;
        1:       din0 = 9'h1FF;
        default: din0 = 9'($urandom);
      endcase
      case ($urandom_range(0, 3))
        0:       din1 = 7'h40;
        1:       din1 = 7'h7F;
        default: din1 = 7'($urandom);
      endcase
      cyc();
    end
    reset = 0; ce = 1; drv(0, 0, 0, 0);
    repeat (8) cyc();

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule
